// File: rtl/shift_seq.sv
// ---------------------------------------------------------------------------
// shift_seq -- sequenced shift register with start/busy/done handshake.
//
// Holds a data_width-bit register that can be parallel-loaded, or shifted
// autonomously by a programmed number of single-bit positions, either toward
// the MSB or toward the LSB. Each shift either fills from a serial input or
// rotates. Usable as a serialiser, deserialiser or multi-cycle barrel shifter.
//
// Optional feature: define SHIFT_SEQ_ABORT_EN to add the abort input and the
// aborted output, which allow a running sequence to be cut short.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   load       in   parallel-load request (IDLE only, wins over start)
//   d          in   parallel load data [data_width]
//   start      in   begin a shift sequence (IDLE only)
//   dir        in   0 = toward MSB, 1 = toward LSB (latched on start)
//   rotate     in   1 = rotate, 0 = fill from serial input (latched on start)
//   count      in   number of single-bit shifts [cnt_width] (latched on start)
//   left_in    in   serial bit entering q[0] on a toward-MSB fill shift
//   right_in   in   serial bit entering q[data_width-1] on a toward-LSB fill
//   abort      in   (SHIFT_SEQ_ABORT_EN only) stop the running sequence
//   busy       out  high while shifting
//   done       out  one-cycle completion pulse
//   aborted    out  (SHIFT_SEQ_ABORT_EN only) one-cycle abort pulse
//   serial_out out  bit that the next shift will drop
//   q          out  register contents [data_width]
// ---------------------------------------------------------------------------
module shift_seq #(
   parameter int data_width = 8,
   parameter int cnt_width  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [data_width-1:0] d,
   input  logic                  start,
   input  logic                  dir,
   input  logic                  rotate,
   input  logic [cnt_width-1:0]  count,
   input  logic                  left_in,
   input  logic                  right_in,
`ifdef SHIFT_SEQ_ABORT_EN
   input  logic                  abort,
   output logic                  aborted,
`endif
   output logic                  busy,
   output logic                  done,
   output logic                  serial_out,
   output logic [data_width-1:0] q
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

   state_t                state, state_nxt;
   logic [data_width-1:0] q_r, q_nxt;
   logic [cnt_width-1:0]  remaining, remaining_nxt;
   logic                  dir_l, dir_nxt;
   logic                  rot_l, rot_nxt;
   logic                  done_r, done_nxt;
`ifdef SHIFT_SEQ_ABORT_EN
   logic                  aborted_r, aborted_nxt;
`endif

   // One single-bit shift; the vacated end takes either the bit that falls
   // off the other end (rotate) or the serial input for that direction.
   function automatic logic [data_width-1:0] shift_one(
      input logic [data_width-1:0] v,
      input logic                  to_lsb,
      input logic                  rot,
      input logic                  lin,
      input logic                  rin
   );
      logic [data_width-1:0] res;
      if (!to_lsb)
         res = {v[data_width-2:0], (rot ? v[data_width-1] : lin)};
      else
         res = {(rot ? v[0] : rin), v[data_width-1:1]};
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         q_r       <= '0;
         remaining <= '0;
         dir_l     <= 1'b0;
         rot_l     <= 1'b0;
         done_r    <= 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
         aborted_r <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         q_r       <= q_nxt;
         remaining <= remaining_nxt;
         dir_l     <= dir_nxt;
         rot_l     <= rot_nxt;
         done_r    <= done_nxt;
`ifdef SHIFT_SEQ_ABORT_EN
         aborted_r <= aborted_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt     = state;
      q_nxt         = q_r;
      remaining_nxt = remaining;
      dir_nxt       = dir_l;
      rot_nxt       = rot_l;
      done_nxt      = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
      aborted_nxt   = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (load) begin
               q_nxt = d;
            end else if (start) begin
               if (count == '0) begin
                  // Nothing to shift: acknowledge immediately.
                  done_nxt = 1'b1;
               end else begin
                  // The accepting edge only latches; shifting starts next edge.
                  dir_nxt       = dir;
                  rot_nxt       = rotate;
                  remaining_nxt = count;
                  state_nxt     = SHIFT;
               end
            end
         end
         SHIFT: begin
`ifdef SHIFT_SEQ_ABORT_EN
            if (abort) begin
               state_nxt     = IDLE;
               remaining_nxt = '0;
               aborted_nxt   = 1'b1;
            end else
`endif
            begin
               q_nxt         = shift_one(q_r, dir_l, rot_l, left_in, right_in);
               remaining_nxt = remaining - CNT_ONE;
               if (remaining == CNT_ONE) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // While shifting, the drop-out bit follows the latched direction; in IDLE
   // it previews what a shift with the live dir input would drop.
   logic eff_dir;
   assign eff_dir    = (state == SHIFT) ? dir_l : dir;
   assign serial_out = eff_dir ? q_r[0] : q_r[data_width-1];

   assign busy = (state == SHIFT);
   assign done = done_r;
   assign q    = q_r;
`ifdef SHIFT_SEQ_ABORT_EN
   assign aborted = aborted_r;
`endif

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;

   logic       clk = 1'b0;
   logic       rst, load, start, dir, rotate, left_in, right_in;
   logic [7:0] d;
   logic [3:0] count;
   logic       busy, done, serial_out;
   logic [7:0] q;
`ifdef SHIFT_SEQ_ABORT_EN
   logic       abort, aborted;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] q;
      int         blen;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   shift_seq #(.data_width(8), .cnt_width(4)) dut (
      .clk(clk),
      .rst(rst),
      .load(load),
      .d(d),
      .start(start),
      .dir(dir),
      .rotate(rotate),
      .count(count),
      .left_in(left_in),
      .right_in(right_in),
`ifdef SHIFT_SEQ_ABORT_EN
      .abort(abort),
      .aborted(aborted),
`endif
      .busy(busy),
      .done(done),
      .serial_out(serial_out),
      .q(q)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges from the current point until done is seen, clearing the
   // one-cycle request inputs after the first edge.
   task automatic wait_done(input int exp_edges, input string name);
      int edges = 0;
      bit seen  = 0;
      while (!seen && edges < 40) begin
         tick();
         edges++;
         start = 1'b0;
         load  = 1'b0;
         if (done === 1'b1) seen = 1;
      end
      chk(name, edges, exp_edges);
   endtask

   // Scoreboard monitor: every done pulse must match a queued expectation.
   int run = 0;
   always @(negedge clk) begin
      if (busy === 1'b1) begin
         run++;
      end else begin
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_q", q, e.q);
               chk("sb_busy_len", run, e.blen);
            end
         end
         run = 0;
      end
      if (done === 1'b1) chk("done_with_busy", busy, 0);
   end

   int so_exp[9] = '{1, 0, 0, 0, 0, 0, 0, 1, 1};

   initial begin
      rst = 1'b1; load = 1'b0; d = '0; start = 1'b0; dir = 1'b0;
      rotate = 1'b0; count = '0; left_in = 1'b0; right_in = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      tick(); tick();
      chk("rst_q", q, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;

      // Reset in the middle of a sequence
      load = 1'b1; d = 8'h3C;
      tick();
      load = 1'b0;
      chk("load_3c", q, 8'h3C);
      start = 1'b1; count = 4'd5; dir = 1'b0; rotate = 1'b0; left_in = 1'b0;
      tick();
      start = 1'b0;
      chk("busy_after_accept", busy, 1);
      tick(); tick();
      chk("two_shifts", q, 8'hF0);
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("midrst_q", q, 8'h00);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      repeat (4) tick();

      // Fill toward MSB
      load = 1'b1; d = 8'hA5;
      tick();
      load = 1'b0; left_in = 1'b1;
      sb.push_back('{8'h2F, 3});
      start = 1'b1; count = 4'd3; dir = 1'b0; rotate = 1'b0;
      wait_done(4, "lat_fill");
      left_in = 1'b0;

      // Rotate toward LSB by 9, watching serial_out each busy cycle
      tick();
      load = 1'b1; d = 8'h81;
      tick();
      load = 1'b0;
      sb.push_back('{8'hC0, 9});
      start = 1'b1; count = 4'd9; dir = 1'b1; rotate = 1'b1;
      tick();
      start = 1'b0; dir = 1'b0;
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("serial_out_%0d", i), serial_out, so_exp[i]);
         tick();
      end
      chk("rot_done", done, 1);
      #1;
      chk("idle_so_dir0", serial_out, 1);
      dir = 1'b1;
      #1;
      chk("idle_so_dir1", serial_out, 0);
      tick();

      // count = 0 and load/start priority
      sb.push_back('{8'hC0, 0});
      start = 1'b1; count = 4'd0;
      wait_done(1, "lat_cnt0");
      load = 1'b1; start = 1'b1; d = 8'h5A; count = 4'd3;
      tick();
      load = 1'b0; start = 1'b0;
      chk("prio_q", q, 8'h5A);
      chk("prio_busy", busy, 0);
      chk("prio_done", done, 0);
      tick();
      chk("prio_busy2", busy, 0);
      chk("prio_done2", done, 0);

      // Requests ignored while busy, then back-to-back start in done cycle
      sb.push_back('{8'hA5, 4});
      start = 1'b1; dir = 1'b0; rotate = 1'b1; count = 4'd4;
      tick();
      start = 1'b1; count = 4'd2; load = 1'b1; d = 8'hFF;
      wait_done(4, "lat_busy_ignore");
      sb.push_back('{8'h29, 2});
      start = 1'b1; dir = 1'b1; rotate = 1'b0; right_in = 1'b0; count = 4'd2;
      wait_done(3, "lat_b2b");

`ifdef SHIFT_SEQ_ABORT_EN
      tick();
      load = 1'b1; d = 8'h01;
      tick();
      load = 1'b0;
      start = 1'b1; dir = 1'b0; rotate = 1'b0; count = 4'd6; left_in = 1'b0;
      tick();
      start = 1'b0;
      tick(); tick();
      chk("abort_pre_q", q, 8'h04);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_q", q, 8'h04);
      chk("abort_busy", busy, 0);
      chk("abort_pulse", aborted, 1);
      chk("abort_done", done, 0);
      tick();
      chk("abort_pulse_end", aborted, 0);
      chk("abort_done2", done, 0);
      chk("abort_busy2", busy, 0);
`endif

      repeat (8) tick();
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
